// File: rtl/fifo_stream_reader.sv
// Read-side adapter: pops a registered-output FIFO and re-presents its words as a
// valid/ready stream through a 2-entry skid buffer that absorbs the read latency.
module fifo_stream_reader #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_rempty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_r_en,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  pop_count
);

    logic [DATA_W-1:0] buf_mem [2];
    logic              head;
    logic              tail;
    logic [1:0]        occ;
    logic              inflight;
    logic              xfer;
    logic [1:0]        committed;

    assign m_valid = (occ != 2'd0);
    assign m_data  = buf_mem[head];
    assign xfer    = m_valid & m_ready;
    assign busy    = m_valid | inflight;

    // Slots still claimed once this cycle's transfer leaves; occ + inflight never exceeds 2.
    assign committed = occ + {1'b0, inflight} - {1'b0, xfer};
    assign fifo_r_en = rst & enable & ~fifo_rempty & (committed < 2'd2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                buf_mem[i] <= '0;
            end
            head      <= 1'b0;
            tail      <= 1'b0;
            occ       <= '0;
            inflight  <= 1'b0;
            pop_count <= '0;
        end else begin
            inflight <= fifo_r_en;
            if (inflight) begin
                buf_mem[tail] <= fifo_rdata;
                tail          <= ~tail;
            end
            if (xfer) begin
                head      <= ~head;
                pop_count <= pop_count + 1'b1;
            end
            if (inflight && !xfer) begin
                occ <= occ + 2'd1;
            end else if (!inflight && xfer) begin
                occ <= occ - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and randomized bench for fifo_stream_reader against a FIFO model and a
// word-ordering/latency reference kept as queues of popped words and their pop cycles.
module tb_fifo_stream_reader;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              fifo_rempty;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_r_en;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic              busy;
    logic [CNT_W-1:0]  pop_count;

    fifo_stream_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_rempty(fifo_rempty),
        .fifo_rdata (fifo_rdata),
        .fifo_r_en  (fifo_r_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .busy       (busy),
        .pop_count  (pop_count)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [256];
    int unsigned       wr_ptr = 0;
    int unsigned       rd_ptr = 0;
    assign fifo_rempty = (wr_ptr == rd_ptr);

    logic [DATA_W-1:0] exp_d [$];
    int                exp_c [$];
    int                cyc = 0;
    int                delivered = 0;
    int                pulses = 0;
    int                first_v = -1;
    int                total = 0;
    int                bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        mem[wr_ptr % 256] = w;
        wr_ptr++;
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic tick();
        logic        exp_v;
        logic        exp_r;
        logic        x_s;
        logic        r_s;
        logic        was_empty;
        int unsigned outstanding;
        logic [DATA_W-1:0] w;
        #1;
        exp_v = 1'b0;
        if (exp_d.size() > 0) exp_v = (exp_c[0] + 2 <= cyc);
        outstanding = exp_d.size();
        exp_r = rst && enable && !fifo_rempty &&
                ((outstanding - ((exp_v && m_ready) ? 1 : 0)) < 2);
        chk("m_valid", 32'(m_valid), 32'(exp_v));
        chk("fifo_r_en", 32'(fifo_r_en), 32'(exp_r));
        if (exp_v) chk("m_data", 32'(m_data), 32'(exp_d[0]));
        chk("busy", 32'(busy), 32'(outstanding != 0));
        chk("pop_count", 32'(pop_count), 32'(delivered % (1 << CNT_W)));
        if (m_valid && first_v < 0) first_v = cyc;
        x_s = exp_v && m_ready;
        r_s = fifo_r_en;
        was_empty = fifo_rempty;
        if (r_s) pulses++;
        @(posedge clk);
        #1;
        if (x_s) begin
            void'(exp_d.pop_front());
            void'(exp_c.pop_front());
            delivered++;
        end
        if (r_s && !was_empty) begin
            w = mem[rd_ptr % 256];
            fifo_rdata = w;
            exp_d.push_back(w);
            exp_c.push_back(cyc);
            rd_ptr++;
        end
        chk("no_overflow", 32'(exp_d.size() <= 2), 32'd1);
        cyc++;
        @(negedge clk);
    endtask

    // Asserted mid-cycle so the checks see the asynchronous clear before any clock edge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_r_en", 32'(fifo_r_en), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_pop_count", 32'(pop_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        exp_d.delete();
        exp_c.delete();
        delivered = 0;
        wr_ptr = rd_ptr;
        fifo_rdata = '0;
        @(negedge clk);
        tick();
    endtask

    initial begin
        rst = 1'b0;
        enable = 1'b1;
        m_ready = 1'b1;
        fifo_rdata = '0;
        @(negedge clk);
        do_reset();

        // Reset held with a non-empty FIFO
        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
        tick();
        chk("rst_hold_r_en", 32'(fifo_r_en), 32'd0);
        chk("rst_hold_busy", 32'(busy), 32'd0);
        rst = 1'b1;

        // Streaming
        cyc = 0; pulses = 0; first_v = -1;
        for (int i = 0; i < 8; i++) tick();
        chk("stream_first_valid", 32'(first_v), 32'd2);
        chk("stream_pulses", 32'(pulses), 32'd5);
        chk("stream_count", 32'(pop_count), 32'd5);
        chk("stream_busy", 32'(busy), 32'd0);

        // Backpressure
        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
        m_ready = 1'b0; pulses = 0;
        for (int i = 0; i < 6; i++) tick();
        chk("bp_pulses", 32'(pulses), 32'd2);
        chk("bp_hold_data", 32'(m_data), 32'h11);
        chk("bp_hold_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1; pulses = 0;
        tick();
        m_ready = 1'b0;
        chk("bp_one_pop", 32'(pulses), 32'd1);
        chk("bp_next_data", 32'(m_data), 32'h12);
        tick(); tick();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("bp_count", 32'(pop_count), 32'd10);
        chk("bp_drained", 32'(wr_ptr - rd_ptr), 32'd0);

        // Empty FIFO, then a single word
        pulses = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("empty_pulses", 32'(pulses), 32'd0);
        chk("empty_valid", 32'(m_valid), 32'd0);
        push(8'hA5);
        cyc = 0; first_v = -1;
        for (int i = 0; i < 5; i++) tick();
        chk("single_pulses", 32'(pulses), 32'd1);
        chk("single_latency", 32'(first_v), 32'd2);
        chk("single_count", 32'(pop_count), 32'd11);

        // Enable drop after the second pop
        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
        pulses = 0;
        tick(); tick();
        enable = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("en_pulses", 32'(pulses), 32'd2);
        chk("en_remaining", 32'(wr_ptr - rd_ptr), 32'd3);
        chk("en_count", 32'(pop_count), 32'd13);
        enable = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("en_resume_count", 32'(pop_count), 32'd0);
        chk("en_drained", 32'(wr_ptr - rd_ptr), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) push(DATA_W'($urandom));
            enable  = ($urandom_range(0, 3) != 0);
            m_ready = $urandom_range(0, 1) != 0;
            tick();
        end
        enable = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (wr_ptr == rd_ptr && exp_d.size() == 0) break;
            tick();
        end
        chk("rand_drained", 32'(exp_d.size() + (wr_ptr - rd_ptr)), 32'd0);

        // Counter wrap
        do_reset();
        rst = 1'b1;
        for (int i = 0; i < 17; i++) push(DATA_W'($urandom));
        for (int i = 0; i < 22; i++) tick();
        chk("wrap_count", 32'(pop_count), 32'd1);

        // Mid-stream resets: full buffer under backpressure, then while streaming
        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_full_busy", 32'(busy), 32'd1);
        do_reset();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h21 + 8'(i));
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("mid_stream_valid", 32'(m_valid), 32'd1);
        do_reset();
        rst = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
